move_cmd_generator: RTL and testbench
=====================================

MOVE_CMD_GENERATOR -- requirements
Module: move_cmd_generator

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning the number of clk cycles a synchronized switch value must hold before it is accepted.
REQ-002 The module SHALL have parameter CNT_W, default 20, meaning the debounce counter width; it SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 The module SHALL have parameter REPEAT_FRAMES, default 8, meaning the frame_tick count between auto-repeat requests.
REQ-004 clk  input  1  system clock (50 MHz).
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 switch  input  2  raw, asynchronous direction switches.
REQ-007 frame_tick  input  1  one-cycle pulse, once per video frame, clk domain.
REQ-008 move_ack  input  1  downstream piece mover accepts the current request.
REQ-009 move_req  output  1  move request pending.
REQ-010 move_dir  output  2  direction latched with the request.
REQ-011 sw_stable  output  2  debounced switch value.
REQ-012 overrun  output  1  sticky flag: a frame_tick arrived while a request was outstanding.

Function
REQ-013 Each switch bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Per bit, the debounce counter SHALL clear while the synchronized value equals the sw_stable value, and SHALL increment otherwise.
REQ-015 When a counter reaches DEBOUNCE_CYCLES-1 with a differing input, the sw_stable bit SHALL take the synchronized value on that edge and the counter SHALL clear.
REQ-016 A clean switch edge SHALL appear on sw_stable exactly 2+DEBOUNCE_CYCLES clk cycles after the pin changes.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL NOT change sw_stable.
REQ-018 A press SHALL be registered in a pending flag when sw_stable changes to a nonzero value.
REQ-019 A change between two nonzero values SHALL count as a new press.
REQ-020 Changing sw_stable to 2'b00 SHALL clear the pending flag.
REQ-021 The FSM SHALL have two states, IDLE and REQ.
REQ-022 IDLE: on frame_tick with the pending flag set, the FSM SHALL latch move_dir = sw_stable, assert move_req on the next cycle, clear the pending flag, and enter REQ.
REQ-023 REQ: move_req and move_dir SHALL hold stable until move_ack is sampled high; move_req SHALL then deassert on the next cycle and the FSM SHALL return to IDLE.
REQ-024 A frame_tick sampled in REQ, including in the same cycle as move_ack, SHALL be dropped and SHALL set overrun.
REQ-025 A press arriving while in REQ SHALL remain pending and SHALL be served at the first frame_tick in IDLE.
REQ-026 move_ack sampled in IDLE SHALL be ignored.
REQ-027 At most one request SHALL be issued per frame_tick.

Reset
REQ-028 While reset is low, the module SHALL force move_req=0, move_dir=2'b00, sw_stable=2'b00, overrun=0, all counters, synchronizers and the pending flag to 0, and the FSM to IDLE, asynchronously.
REQ-029 A reset asserted while in REQ SHALL abort the request without waiting for move_ack.

Configuration
REQ-030 With macro MOVE_REPEAT_EN defined, while sw_stable stays at the same nonzero value, the module SHALL set the pending flag every REPEAT_FRAMES frame_ticks after the initial press; the repeat counter SHALL clear on any sw_stable change.
REQ-031 Without MOVE_REPEAT_EN, the module SHALL issue exactly one request per press, and no repeat counter logic SHALL exist.

Verification (DEBOUNCE_CYCLES=4, REPEAT_FRAMES=3)
REQ-032 The bench SHALL drive switch 00->01 held, then check: sw_stable=01 exactly 6 cycles later, and move_req=1 with move_dir=01 one cycle after the next frame_tick.
REQ-033 The bench SHALL drive a 3-cycle pulse of switch=10, then check: sw_stable stays 00 and move_req stays 0 across 5 frame_ticks.
REQ-034 The bench SHALL withhold move_ack for 2 frame_ticks, then check: move_req/move_dir stay stable, overrun=1, and move_req=0 one cycle after move_ack.
REQ-035 The bench SHALL assert frame_tick and move_ack in the same cycle in REQ, then check: the FSM returns to IDLE, overrun=1, and no new request is issued that cycle.
REQ-036 The bench SHALL hold switch=11 for 7 frame_ticks, then check: with MOVE_REPEAT_EN, requests are issued on ticks 1, 4 and 7; without it, a request is issued on tick 1 only.
REQ-037 The bench SHALL pulse reset low while move_req=1, then check: all outputs are 0 immediately, and no request is issued until a new press.

Source files
------------

// File: rtl/move_cmd_generator.sv
// ---------------------------------------------------------------------------
// move_cmd_generator
//
// Turns two raw direction switches into frame-paced move requests for a
// downstream piece mover. Each switch bit is synchronized, then debounced.
// A change of the debounced value to a nonzero code is a "press". Presses are
// served one per frame_tick through a small IDLE/REQ handshake FSM.
//
// Parameters
//   DEBOUNCE_CYCLES : clk cycles a synchronized value must hold to be accepted
//   CNT_W           : debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//   REPEAT_FRAMES   : frame_ticks between auto-repeat presses
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-low reset
//   switch     in   [1:0] raw asynchronous direction switches
//   frame_tick in   one-cycle pulse once per video frame
//   move_ack   in   downstream mover accepts the current request
//   move_req   out  move request pending
//   move_dir   out  [1:0] direction latched with the request
//   sw_stable  out  [1:0] debounced switch value
//   overrun    out  sticky: a frame_tick arrived while a request was outstanding
//
// Build option
//   MOVE_REPEAT_EN : when defined, a held nonzero switch value re-arms the
//                    pending press every REPEAT_FRAMES frame_ticks.
// ---------------------------------------------------------------------------
module move_cmd_generator #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_FRAMES   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] switch,
    input  logic       frame_tick,
    input  logic       move_ack,
    output logic       move_req,
    output logic [1:0] move_dir,
    output logic [1:0] sw_stable,
    output logic       overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    logic [1:0]       swSync1_q;
    logic [1:0]       swSync2_q;
    logic [CNT_W-1:0] dbCnt_q [2];
    logic [CNT_W-1:0] dbCnt_d [2];
    logic [1:0]       stable_q;
    logic [1:0]       stable_d;
    logic             pend_q;
    logic             pend_d;
    state_t           state_q;
    state_t           state_d;
    logic [1:0]       dir_q;
    logic [1:0]       dir_d;
    logic             ovr_q;
    logic             ovr_d;
    logic             take;
    logic             stableChg;

    // Two-flop synchronizer per switch bit; nothing downstream sees the raw pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            swSync1_q <= 2'b00;
            swSync2_q <= 2'b00;
        end else begin
            swSync1_q <= switch;
            swSync2_q <= swSync1_q;
        end
    end

    // Per-bit debounce: the counter runs only while the synchronized bit
    // disagrees with the accepted value. On the cycle the counter already
    // reads DEBOUNCE_CYCLES-1 the new value is accepted, so a clean edge
    // lands on sw_stable 2 + DEBOUNCE_CYCLES cycles after the pin moves.
    always_comb begin
        dbCnt_d  = dbCnt_q;
        stable_d = stable_q;
        for (int b = 0; b < 2; b++) begin
            if (swSync2_q[b] == stable_q[b]) begin
                dbCnt_d[b] = '0;
            end else if (dbCnt_q[b] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d[b] = swSync2_q[b];
                dbCnt_d[b]  = '0;
            end else begin
                dbCnt_d[b] = dbCnt_q[b] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dbCnt_q[0] <= '0;
            dbCnt_q[1] <= '0;
            stable_q   <= 2'b00;
        end else begin
            dbCnt_q[0] <= dbCnt_d[0];
            dbCnt_q[1] <= dbCnt_d[1];
            stable_q   <= stable_d;
        end
    end

    assign stableChg = (stable_d != stable_q);

`ifdef MOVE_REPEAT_EN
    localparam int REP_W = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;

    logic [REP_W-1:0] repCnt_q;
    logic [REP_W-1:0] repCnt_d;
    logic             repFire;

    // Auto-repeat: count frame_ticks while the debounced value sits at the
    // same nonzero code, re-arming the pending press each REPEAT_FRAMES ticks.
    always_comb begin
        repCnt_d = repCnt_q;
        repFire  = 1'b0;
        if (stableChg) begin
            repCnt_d = '0;
        end else if (frame_tick && (stable_q != 2'b00)) begin
            if (repCnt_q == REP_W'(REPEAT_FRAMES - 1)) begin
                repFire  = 1'b1;
                repCnt_d = '0;
            end else begin
                repCnt_d = repCnt_q + REP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            repCnt_q <= '0;
        end else begin
            repCnt_q <= repCnt_d;
        end
    end
`endif

    // Pending press flag. The FSM consuming it is applied first so a press
    // detected in the same cycle survives and waits for the next frame.
    always_comb begin
        pend_d = pend_q;
        if (take) begin
            pend_d = 1'b0;
        end
        if (stableChg) begin
            pend_d = (stable_d != 2'b00);
        end
`ifdef MOVE_REPEAT_EN
        if (repFire) begin
            pend_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Request handshake. Any frame_tick seen in REQ is dropped and flagged,
    // even when it coincides with move_ack, so at most one request per tick.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        ovr_d   = ovr_q;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_tick && pend_q) begin
                    take    = 1'b1;
                    dir_d   = stable_q;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (frame_tick) begin
                    ovr_d = 1'b1;
                end
                if (move_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            dir_q   <= 2'b00;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            ovr_q   <= ovr_d;
        end
    end

    assign move_req  = (state_q == REQ);
    assign move_dir  = dir_q;
    assign sw_stable = stable_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_move_cmd_generator.sv
// ---------------------------------------------------------------------------
// tb_move_cmd_generator
//
// Directed bench for move_cmd_generator with DEBOUNCE_CYCLES=4 and
// REPEAT_FRAMES=3. Inputs change 1 time unit after a rising edge and outputs
// are sampled at that same point, well away from the active edge.
// Expectations for the auto-repeat scenario follow MOVE_REPEAT_EN.
// ---------------------------------------------------------------------------
module tb_move_cmd_generator;

    localparam int DEBOUNCE_CYCLES = 4;
    localparam int CNT_W           = 4;
    localparam int REPEAT_FRAMES   = 3;

    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic [1:0] switch     = 2'b00;
    logic       frame_tick = 1'b0;
    logic       move_ack   = 1'b0;
    logic       move_req;
    logic [1:0] move_dir;
    logic [1:0] sw_stable;
    logic       overrun;

    int vectors     = 0;
    int miscompares = 0;

    move_cmd_generator #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .REPEAT_FRAMES   (REPEAT_FRAMES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .switch     (switch),
        .frame_tick (frame_tick),
        .move_ack   (move_ack),
        .move_req   (move_req),
        .move_dir   (move_dir),
        .sw_stable  (sw_stable),
        .overrun    (overrun)
    );

    // 10 time-unit clock.
    always #5 clk = ~clk;

    // Advance n rising edges, landing 1 unit after the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a new raw switch value.
    task automatic applyStimulus(input logic [1:0] sw);
        switch = sw;
    endtask

    // One-cycle frame_tick pulse; returns just after the edge that sampled it.
    task automatic pulseTick();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
    endtask

    // One-cycle move_ack pulse; returns just after the edge that sampled it.
    task automatic pulseAck();
        move_ack = 1'b1;
        cyc(1);
        move_ack = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin : stim
        logic expReq;

        // Reset asserted from time zero: every output must be low.
        #1;
        checkOutput("rst_move_req", {3'b0, move_req}, 4'h0);
        checkOutput("rst_move_dir", {2'b0, move_dir}, 4'h0);
        checkOutput("rst_sw_stable", {2'b0, sw_stable}, 4'h0);
        checkOutput("rst_overrun", {3'b0, overrun}, 4'h0);
        cyc(2);
        reset = 1'b1;
        cyc(1);

        // Clean 00->01 edge: accepted exactly 6 cycles after the pin moves.
        applyStimulus(2'b01);
        cyc(5);
        checkOutput("deb_not_yet", {2'b0, sw_stable}, 4'h0);
        cyc(1);
        checkOutput("deb_accept", {2'b0, sw_stable}, 4'h1);
        cyc(2);
        checkOutput("no_req_before_tick", {3'b0, move_req}, 4'h0);
        pulseTick();
        checkOutput("req_after_tick", {3'b0, move_req}, 4'h1);
        checkOutput("dir_after_tick", {2'b0, move_dir}, 4'h1);

        // Withhold the ack over two frame_ticks: request holds, overrun sets.
        cyc(2);
        pulseTick();
        cyc(2);
        pulseTick();
        checkOutput("hold_req", {3'b0, move_req}, 4'h1);
        checkOutput("hold_dir", {2'b0, move_dir}, 4'h1);
        checkOutput("overrun_set", {3'b0, overrun}, 4'h1);
        pulseAck();
        checkOutput("req_drop_after_ack", {3'b0, move_req}, 4'h0);

        // Ack seen in IDLE is ignored and does not create a request.
        cyc(1);
        pulseAck();
        cyc(1);
        checkOutput("idle_ack_ignored", {3'b0, move_req}, 4'h0);

        // Release switches back to 00.
        applyStimulus(2'b00);
        cyc(6);
        checkOutput("release_stable", {2'b0, sw_stable}, 4'h0);

        // 3-cycle glitch to 10 must never reach sw_stable.
        applyStimulus(2'b10);
        cyc(3);
        applyStimulus(2'b00);
        cyc(6);
        checkOutput("glitch_stable", {2'b0, sw_stable}, 4'h0);
        for (int i = 0; i < 5; i++) begin
            cyc(2);
            pulseTick();
            checkOutput("glitch_no_req", {3'b0, move_req}, 4'h0);
            checkOutput("glitch_stable_tick", {2'b0, sw_stable}, 4'h0);
        end

        // New press 10, issue a request, then reset mid-request.
        applyStimulus(2'b10);
        cyc(6);
        checkOutput("press10_stable", {2'b0, sw_stable}, 4'h2);
        pulseTick();
        checkOutput("press10_req", {3'b0, move_req}, 4'h1);
        checkOutput("press10_dir", {2'b0, move_dir}, 4'h2);
        reset = 1'b0;
        applyStimulus(2'b00);
        #1;
        checkOutput("abort_move_req", {3'b0, move_req}, 4'h0);
        checkOutput("abort_move_dir", {2'b0, move_dir}, 4'h0);
        checkOutput("abort_sw_stable", {2'b0, sw_stable}, 4'h0);
        checkOutput("abort_overrun", {3'b0, overrun}, 4'h0);
        cyc(2);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(3);
            pulseTick();
            checkOutput("post_reset_no_req", {3'b0, move_req}, 4'h0);
        end
        checkOutput("post_reset_overrun", {3'b0, overrun}, 4'h0);

        // frame_tick and move_ack together in REQ: back to IDLE, tick dropped.
        applyStimulus(2'b01);
        cyc(6);
        checkOutput("press01_stable", {2'b0, sw_stable}, 4'h1);
        pulseTick();
        checkOutput("press01_req", {3'b0, move_req}, 4'h1);
        cyc(1);
        frame_tick = 1'b1;
        move_ack   = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        move_ack   = 1'b0;
        checkOutput("tick_ack_idle", {3'b0, move_req}, 4'h0);
        checkOutput("tick_ack_overrun", {3'b0, overrun}, 4'h1);
        cyc(1);
        checkOutput("tick_ack_no_new_req", {3'b0, move_req}, 4'h0);
        applyStimulus(2'b00);
        cyc(6);
        checkOutput("release2_stable", {2'b0, sw_stable}, 4'h0);

        // Hold 11 across 7 frame_ticks; acknowledge every request promptly.
        applyStimulus(2'b11);
        cyc(6);
        checkOutput("press11_stable", {2'b0, sw_stable}, 4'h3);
        for (int k = 1; k <= 7; k++) begin
            cyc(2);
            pulseTick();
`ifdef MOVE_REPEAT_EN
            expReq = (k == 1) || (k == 4) || (k == 7);
`else
            expReq = (k == 1);
`endif
            checkOutput($sformatf("repeat_tick%0d_req", k), {3'b0, move_req}, {3'b0, expReq});
            if (expReq) begin
                checkOutput($sformatf("repeat_tick%0d_dir", k), {2'b0, move_dir}, 4'h3);
                pulseAck();
                checkOutput($sformatf("repeat_tick%0d_ack", k), {3'b0, move_req}, 4'h0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
